fsm_trans_checker: RTL and testbench
====================================

Name: fsm_trans_checker

Overview:
- Runtime-loadable transition checker for the team's Moore FSM benches.
- Accepts transition entries packed {state, input, next}, 12 bits at default widths, e.g. {4'b0000, 4'b1000, 4'b0110}, through a valid/ready load port into an internal table.
- Then monitors a DUT state/input stream and flags every illegal state change.
- Also counts checked steps, errors and distinct covered transitions. This makes it the consuming end of the transition-table format the bench already produces.

Parameters:
- SW, 4, state width in bits.
- IW, 4, input width in bits.
- CNT_W, 16, width of all counters; counters saturate at all-ones.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- tbl_valid  in  1  load entry valid.
- tbl_ready  out  1  load entry accepted when tbl_valid & tbl_ready.
- tbl_data  in  2*SW+IW  entry {state[SW], input[IW], next[SW]}, MSB first.
- tbl_last  in  1  marks final entry; accepted with it.
- mon_valid  in  1  monitor beat valid.
- mon_state  in  SW  DUT state this beat.
- mon_in  in  IW  DUT input this beat.
- run  out  1  table loaded, checking active.
- err  out  1  one-cycle pulse per detected mismatch.
- dup_err  out  1  sticky: a (state,input) pair was loaded twice.
- err_cnt  out  CNT_W  mismatch count.
- chk_cnt  out  CNT_W  checked steps.
- cov_cnt  out  CNT_W  distinct loaded transitions exercised.
- first_exp  out  SW  expected state at first mismatch.
- first_got  out  SW  observed state at first mismatch.

Behaviour:
- Table: 2^(SW+IW) entries, each {vld, next, hit}, addressed by {state, input}.
- Reset: all outputs 0. Control FSM enters CLEAR; the monitor pipeline is flushed.
- Control FSM states: CLEAR -> LOAD -> RUN.
- CLEAR:
  - Clears vld/hit of entry k on cycle k. Takes exactly 2^(SW+IW) cycles (256 at defaults).
  - tbl_ready=0. Then LOAD.
- LOAD:
  - tbl_ready=1. On handshake, write {vld=1, next}.
  - If the entry is already vld: overwrite and set dup_err.
  - A handshake with tbl_last -> RUN on the next cycle.
  - A zero-entry table is legal only via tbl_last on a valid entry.
  - mon_* is ignored in CLEAR and LOAD.
- RUN:
  - tbl_ready=0, run=1. Stays in RUN until rst.
  - Reloading the table requires rst.
- Expected next state for a beat (s,i):
  - the table next if vld;
  - otherwise s, since unlisted pairs hold state (Moore self-loop).
- Checking pipeline:
  - A beat is a cycle with mon_valid=1 in RUN.
  - Beat N is looked up (synchronous read) and its expected state is held.
  - If beat N+1 arrives on the immediately following cycle, mon_state of N+1 is compared with expected(N).
  - A cycle without mon_valid breaks the chain: the next beat is not compared; it only seeds a new lookup.
  - The first beat after entering RUN is never compared.
- Result timing (registered, one cycle after the compared beat):
  - chk_cnt increments on every compare.
  - On mismatch: err=1 and err_cnt increments.
  - On the first mismatch since reset, capture first_exp and first_got. Later mismatches leave them unchanged.
- Coverage:
  - On a compare where entry N is vld, hit=0 and the result matches: set hit and increment cov_cnt.
  - Mismatching or unlisted steps never count.
- Saturation: counters stop at 2^CNT_W-1 and never wrap. err still pulses after err_cnt saturates.
- rst mid-load or mid-run: returns to CLEAR on the next edge. The table, counters and sticky flags are lost. Any in-flight compare is dropped, with no err pulse.

Test Plan:
- Load complete 83-entry table, back-to-back tbl_valid:
  - tbl_ready low for the first 256 cycles after rst;
  - run=1 one cycle after the tbl_last handshake;
  - dup_err=0.
- Legal step:
  - Beats (0,4'b1000) then (4'b0110,x), consecutive -> chk_cnt=1, err_cnt=0, cov_cnt=1.
  - Repeating the same step -> cov_cnt stays 1, chk_cnt=2.
- Unlisted hold:
  - Beats (0,4'b0001) then (0,x) -> no err, cov_cnt unchanged.
  - Beats (0,4'b0001) then (5,x) -> err pulse, first_exp=0, first_got=5.
- Mismatch:
  - Beats (4'b1111,4'b0100) then (4'b0011,x) -> err one cycle later, err_cnt=1, first_exp=4'b1100, first_got=4'b0011.
  - A second mismatch leaves first_* unchanged.
- Gap:
  - Beat (0,4'b1000), idle cycle, beat (5,x) -> no compare, chk_cnt unchanged, no err.
- Duplicate and reset:
  - Load {0,8,6} then {0,8,5} -> dup_err=1; step (0,8)->5 checks clean.
  - Assert rst during RUN with a compare in flight -> no err pulse, all counters 0, run=0, CLEAR restarts.

Source files
------------

// File: rtl/fsm_trans_checker.sv
// Runtime-loadable FSM transition checker: loads a {state,input,next} table, then
// compares each observed state change against it and tracks errors and coverage.
module fsm_trans_checker #(
  parameter int SW    = 4,
  parameter int IW    = 4,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tbl_valid,
  output logic                 tbl_ready,
  input  logic [2*SW+IW-1:0]   tbl_data,
  input  logic                 tbl_last,
  input  logic                 mon_valid,
  input  logic [SW-1:0]        mon_state,
  input  logic [IW-1:0]        mon_in,
  output logic                 run,
  output logic                 err,
  output logic                 dup_err,
  output logic [CNT_W-1:0]     err_cnt,
  output logic [CNT_W-1:0]     chk_cnt,
  output logic [CNT_W-1:0]     cov_cnt,
  output logic [SW-1:0]        first_exp,
  output logic [SW-1:0]        first_got
);

  localparam int AW    = SW + IW;
  localparam int DEPTH = 1 << AW;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2
  } ctl_t;

  ctl_t              state_reg, state_next;
  logic [AW-1:0]     clr_idx_reg;
  logic              clear_en;

  logic              load_wr;
  logic [AW-1:0]     wr_addr;
  logic [SW-1:0]     wr_next;
  logic              dup_hit;

  logic              vld_reg [DEPTH];
  logic              hit_reg [DEPTH];
  logic [SW-1:0]     next_mem [DEPTH];

  logic [AW-1:0]     mon_addr;
  logic              beat_reg;
  logic [AW-1:0]     lk_addr_reg;
  logic [SW-1:0]     lk_state_reg;
  logic              lk_vld_reg;
  logic [SW-1:0]     rd_next_reg;

  logic              cmp_en;
  logic [SW-1:0]     exp_state;
  logic              mism;
  logic              cov_set;
  logic              first_seen_reg;

  // ---------------- control FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= CLEAR;
      clr_idx_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == CLEAR) begin
        clr_idx_reg <= clr_idx_reg + AW'(1);
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    tbl_ready  = 1'b0;
    run        = 1'b0;
    clear_en   = 1'b0;
    case (state_reg)
      CLEAR: begin
        clear_en = 1'b1;
        if (clr_idx_reg == '1) begin
          state_next = LOAD;
        end
      end
      LOAD: begin
        tbl_ready = 1'b1;
        if (tbl_valid && tbl_last) begin
          state_next = RUN;
        end
      end
      RUN: begin
        run = 1'b1;
      end
      default: begin
        state_next = CLEAR;
      end
    endcase
  end

  // ---------------- table storage ----------------
  assign load_wr = tbl_ready && tbl_valid && !rst;
  assign wr_addr = tbl_data[2*SW+IW-1:SW];
  assign wr_next = tbl_data[SW-1:0];
  assign dup_hit = load_wr && vld_reg[wr_addr];

  // Per-entry flag bits: cleared one per cycle while in CLEAR.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (clear_en && (clr_idx_reg == AW'(gi))) begin
        vld_reg[gi] <= 1'b0;
        hit_reg[gi] <= 1'b0;
      end else begin
        if (load_wr && (wr_addr == AW'(gi))) begin
          vld_reg[gi] <= 1'b1;
        end
        if (cov_set && (lk_addr_reg == AW'(gi))) begin
          hit_reg[gi] <= 1'b1;
        end
      end
    end
  end

  assign mon_addr = {mon_state, mon_in};

  always_ff @(posedge clk) begin
    if (load_wr) begin
      next_mem[wr_addr] <= wr_next;
    end
    rd_next_reg <= next_mem[mon_addr];
  end

  // ---------------- lookup stage ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_reg     <= 1'b0;
      lk_addr_reg  <= '0;
      lk_state_reg <= '0;
      lk_vld_reg   <= 1'b0;
    end else begin
      beat_reg <= (state_reg == RUN) && mon_valid;
      if (mon_valid) begin
        lk_addr_reg  <= mon_addr;
        lk_state_reg <= mon_state;
        lk_vld_reg   <= vld_reg[mon_addr];
      end
    end
  end

  // Unlisted pairs are self-loops, so the expected state is the old state.
  assign exp_state = lk_vld_reg ? rd_next_reg : lk_state_reg;
  assign cmp_en    = !rst && (state_reg == RUN) && mon_valid && beat_reg;
  assign mism      = cmp_en && (mon_state != exp_state);
  assign cov_set   = cmp_en && (mon_state == exp_state) && lk_vld_reg && !hit_reg[lk_addr_reg];

  // ---------------- results ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      err            <= 1'b0;
      dup_err        <= 1'b0;
      err_cnt        <= '0;
      chk_cnt        <= '0;
      cov_cnt        <= '0;
      first_exp      <= '0;
      first_got      <= '0;
      first_seen_reg <= 1'b0;
    end else begin
      err <= mism;
      if (dup_hit) begin
        dup_err <= 1'b1;
      end
      if (cmp_en && (chk_cnt != '1)) begin
        chk_cnt <= chk_cnt + CNT_W'(1);
      end
      if (mism) begin
        if (err_cnt != '1) begin
          err_cnt <= err_cnt + CNT_W'(1);
        end
        if (!first_seen_reg) begin
          first_seen_reg <= 1'b1;
          first_exp      <= exp_state;
          first_got      <= mon_state;
        end
      end
      if (cov_set && (cov_cnt != '1)) begin
        cov_cnt <= cov_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fsm_trans_checker.sv
// Self-checking bench for fsm_trans_checker: vector table, corner sequences and
// randomized monitor traffic against a rule-level reference model.
module tb_fsm_trans_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tbl_valid = 1'b0;
  logic        tbl_ready;
  logic [11:0] tbl_data = '0;
  logic        tbl_last = 1'b0;
  logic        mon_valid = 1'b0;
  logic [3:0]  mon_state = '0;
  logic [3:0]  mon_in = '0;
  logic        run, err, dup_err;
  logic [15:0] err_cnt, chk_cnt, cov_cnt;
  logic [3:0]  first_exp, first_got;

  fsm_trans_checker dut (
    .clk(clk), .rst(rst),
    .tbl_valid(tbl_valid), .tbl_ready(tbl_ready), .tbl_data(tbl_data), .tbl_last(tbl_last),
    .mon_valid(mon_valid), .mon_state(mon_state), .mon_in(mon_in),
    .run(run), .err(err), .dup_err(dup_err),
    .err_cnt(err_cnt), .chk_cnt(chk_cnt), .cov_cnt(cov_cnt),
    .first_exp(first_exp), .first_got(first_got)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: the loaded transition set plus the previous beat.
  bit m_vld [256];
  int m_next [256];
  bit m_hit [256];
  int m_chk, m_ecnt, m_cov, m_fe, m_fg;
  bit m_err, m_first, m_dup;
  bit have_prev;
  int prev_s, prev_i;

  int ld_s[$], ld_i[$], ld_n[$];

  typedef struct {
    int s0; int i0; int s1;
    int e_err; int e_chk; int e_ecnt; int e_cov; int e_fe; int e_fg;
  } vec_t;

  vec_t va [6];
  vec_t vb [3];

  task automatic check(input string name, input int got, input int expv);
    checks++;
    if (got != expv) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, got, expv, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void model_reset();
    for (int k = 0; k < 256; k++) begin
      m_vld[k] = 1'b0; m_next[k] = 0; m_hit[k] = 1'b0;
    end
    m_chk = 0; m_ecnt = 0; m_cov = 0; m_fe = 0; m_fg = 0;
    m_err = 1'b0; m_first = 1'b0; m_dup = 1'b0;
    have_prev = 1'b0; prev_s = 0; prev_i = 0;
  endfunction

  function automatic int sat_inc(input int v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  function automatic int model_expect(input int s, input int i);
    int a;
    a = s * 16 + i;
    return m_vld[a] ? m_next[a] : s;
  endfunction

  function automatic void model_beat(input bit v, input int s, input int i);
    int a, e;
    m_err = 1'b0;
    if (v && have_prev) begin
      a = prev_s * 16 + prev_i;
      e = model_expect(prev_s, prev_i);
      m_chk = sat_inc(m_chk);
      if (s != e) begin
        m_err = 1'b1;
        m_ecnt = sat_inc(m_ecnt);
        if (!m_first) begin
          m_first = 1'b1; m_fe = e; m_fg = s;
        end
      end else if (m_vld[a] && !m_hit[a]) begin
        m_hit[a] = 1'b1;
        m_cov = sat_inc(m_cov);
      end
    end
    have_prev = v;
    prev_s = s;
    prev_i = i;
  endfunction

  task automatic check_model();
    check("run", run, 1);
    check("err", err, m_err);
    check("err_cnt", err_cnt, m_ecnt);
    check("chk_cnt", chk_cnt, m_chk);
    check("cov_cnt", cov_cnt, m_cov);
    check("first_exp", first_exp, m_fe);
    check("first_got", first_got, m_fg);
  endtask

  task automatic cyc(input bit v, input int s, input int i);
    mon_valid = v;
    mon_state = 4'(s);
    mon_in    = 4'(i);
    model_beat(v, s, i);
    tick();
    check_model();
  endtask

  task automatic clear_phase();
    int hi;
    hi = 0;
    for (int k = 0; k < 256; k++) begin
      if (tbl_ready || run) hi++;
      tick();
    end
    check("clear_ready_low", hi, 0);
    check("load_ready_high", tbl_ready, 1);
  endtask

  task automatic load_table();
    int w, a;
    w = 0;
    while (!tbl_ready && w < 400) begin
      tick();
      w++;
    end
    check("load_ready_wait", tbl_ready, 1);
    for (int k = 0; k < ld_s.size(); k++) begin
      tbl_valid = 1'b1;
      tbl_data  = 12'((ld_s[k] << 8) | (ld_i[k] << 4) | ld_n[k]);
      tbl_last  = (k == ld_s.size() - 1);
      a = ld_s[k] * 16 + ld_i[k];
      if (m_vld[a]) m_dup = 1'b1;
      m_vld[a] = 1'b1;
      m_next[a] = ld_n[k];
      tick();
    end
    tbl_valid = 1'b0;
    tbl_last  = 1'b0;
    have_prev = 1'b0;
    check("run_after_last", run, 1);
    check("tbl_ready_in_run", tbl_ready, 0);
    check("dup_err", dup_err, m_dup);
  endtask

  task automatic apply_vec(input vec_t v);
    cyc(1'b0, 0, 0);
    cyc(1'b1, v.s0, v.i0);
    cyc(1'b1, v.s1, 0);
    check("vec_err", err, v.e_err);
    check("vec_chk_cnt", chk_cnt, v.e_chk);
    check("vec_err_cnt", err_cnt, v.e_ecnt);
    check("vec_cov_cnt", cov_cnt, v.e_cov);
    check("vec_first_exp", first_exp, v.e_fe);
    check("vec_first_got", first_got, v.e_fg);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int a, s, i;
    bit v;

    va[0] = '{0, 8, 6,  0, 1, 0, 1, 0, 0};
    va[1] = '{0, 8, 6,  0, 2, 0, 1, 0, 0};
    va[2] = '{0, 1, 0,  0, 3, 0, 1, 0, 0};
    va[3] = '{0, 1, 5,  1, 4, 1, 1, 0, 5};
    va[4] = '{15, 4, 3, 1, 5, 2, 1, 0, 5};
    va[5] = '{15, 4, 12, 0, 6, 2, 2, 0, 5};
    vb[0] = '{0, 8, 5,  0, 1, 0, 1, 0, 0};
    vb[1] = '{15, 4, 3, 1, 2, 1, 1, 12, 3};
    vb[2] = '{0, 1, 5,  1, 3, 2, 1, 12, 3};

    // Phase A: reset, full 83-entry table, vectors, gap, random traffic.
    model_reset();
    rst = 1'b1;
    tick();
    tick();
    check("rst_err", err, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_chk_cnt", chk_cnt, 0);
    check("rst_cov_cnt", cov_cnt, 0);
    check("rst_run", run, 0);
    check("rst_dup_err", dup_err, 0);
    check("rst_tbl_ready", tbl_ready, 0);
    rst = 1'b0;
    clear_phase();

    ld_s.push_back(0);  ld_i.push_back(8); ld_n.push_back(6);
    ld_s.push_back(15); ld_i.push_back(4); ld_n.push_back(12);
    for (int k = 0; ld_s.size() < 83; k++) begin
      a = (k * 37 + 11) % 256;
      if (a >= 16 && a != 8'hF4) begin
        ld_s.push_back(a / 16);
        ld_i.push_back(a % 16);
        ld_n.push_back($urandom_range(0, 15));
      end
    end
    load_table();

    for (int k = 0; k < 6; k++) apply_vec(va[k]);
    cyc(1'b0, 0, 0);
    check("err_drops", err, 0);

    cyc(1'b1, 0, 8);
    cyc(1'b0, 0, 0);
    cyc(1'b1, 5, 3);
    check("gap_chk_cnt", chk_cnt, 6);
    check("gap_err", err, 0);
    cyc(1'b0, 0, 0);

    for (int n = 0; n < 1500; n++) begin
      v = ($urandom_range(0, 3) != 0);
      i = $urandom_range(0, 15);
      if (have_prev && $urandom_range(0, 2) != 0) s = model_expect(prev_s, prev_i);
      else s = $urandom_range(0, 15);
      cyc(v, s, i);
    end

    // Reset during RUN with a mismatching compare in flight.
    cyc(1'b0, 0, 0);
    cyc(1'b1, 0, 8);
    mon_valid = 1'b1;
    mon_state = 4'd5;
    mon_in    = 4'd0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mon_valid = 1'b0;
    model_reset();
    check("midrst_err", err, 0);
    check("midrst_err_cnt", err_cnt, 0);
    check("midrst_chk_cnt", chk_cnt, 0);
    check("midrst_cov_cnt", cov_cnt, 0);
    check("midrst_run", run, 0);
    check("midrst_dup_err", dup_err, 0);
    check("midrst_first_exp", first_exp, 0);
    check("midrst_first_got", first_got, 0);
    clear_phase();

    // Phase B: duplicate entry overrides the earlier one.
    ld_s.delete(); ld_i.delete(); ld_n.delete();
    ld_s.push_back(0);  ld_i.push_back(8); ld_n.push_back(6);
    ld_s.push_back(0);  ld_i.push_back(8); ld_n.push_back(5);
    ld_s.push_back(15); ld_i.push_back(4); ld_n.push_back(12);
    load_table();
    check("dup_err_set", dup_err, 1);
    for (int k = 0; k < 3; k++) apply_vec(vb[k]);
    cyc(1'b0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
